fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage for the RV32I core. Owns the program counter.
//  Drives cur_pc into the combinational instruction ROM and captures the
//  returned 32-bit word plus its PC into an IF/ID register.
//  Hands the word to decode over a valid/ready handshake. Accepts branch
//  redirects and halts on the all-zero padding word.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be 4-byte aligned
//  IMEM_BYTES 128            ROM size in bytes; PCs >= this value are out of range
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  cur_pc       out  32  PC presented to the instruction ROM
//  instruction  in   32  ROM word at cur_pc (combinational, same cycle)
//  redirect_en  in   1   taken branch/jump from execute
//  redirect_pc  in   32  redirect target
//  id_ready     in   1   decode accepts the IF/ID contents this cycle
//  if_valid     out  1   IF/ID holds a valid instruction
//  if_pc        out  32  PC of the held instruction
//  if_instr     out  32  held instruction word
//  if_fault     out  1   held entry was fetched from an out-of-range PC
//  misalign     out  1   one-cycle pulse: redirect_pc[1:0] was non-zero
//  halted       out  1   FSM is in HALT
// BEHAVIOUR
//  Reset (async): state=BOOT, cur_pc=RESET_PC, if_valid=0, if_pc=0,
//   if_instr=0, if_fault=0, misalign=0, halted=0.
//  fire = (state==RUN) && (!if_valid || id_ready).
//  FSM states:
//   BOOT: one idle cycle after reset release, then go to RUN. No capture.
//   RUN:
//    - On fire: if_pc<=cur_pc, if_instr<=instruction,
//      if_fault<=(cur_pc>=IMEM_BYTES), if_valid<=1, cur_pc<=cur_pc+4
//      (mod 2^32; wraps silently).
//    - If fire and instruction==32'h0: capture the word as normal, go to
//      HALT, and hold cur_pc.
//    - No fire: hold cur_pc and IF/ID. If if_valid && id_ready, then
//      if_valid<=0.
//   HALT: halted=1 and no capture. IF/ID drains normally (if_valid<=0
//    once id_ready). Only redirect or reset leaves HALT.
//  Redirect (any state, highest priority, takes effect same edge):
//   - cur_pc<={redirect_pc[31:2],2'b00} and if_valid<=0 (flush),
//     regardless of id_ready.
//   - State goes to RUN; from BOOT the BOOT cycle still completes first.
//   - misalign<=|redirect_pc[1:0] for exactly one cycle.
//   - The word at the old cur_pc is discarded.
//  Latency: ROM word appears on if_instr 1 cycle after cur_pc shows it.
//   Sustained throughput is 1 instruction/cycle while id_ready=1.
//  Stability: while if_valid && !id_ready, if_pc, if_instr and if_fault
//   do not change.
//  Out-of-range fetch does not stop the stage; the flag travels with the
//   instruction.
//  Reset mid-operation: all state clears immediately, asynchronously.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - Adds output fetch_count [31:0], reset 0.
//   - Increments on every fire; wraps at 2^32.
//   - Adds output stall_count [31:0], reset 0.
//   - Increments on each RUN cycle where if_valid && !id_ready.
//   - Neither counter changes on redirect cycles.
//  FETCH_PERF_CNT_EN undefined: ports and counters absent; all other
//   behaviour identical.
// TESTING
//  1. Reset, id_ready=1, ROM words A,B,C at 0,4,8 -> cycle after BOOT:
//     if_pc=0/if_instr=A, then 4/B, then 8/C; cur_pc=0xC.
//  2. id_ready=0 for 3 cycles while word at 4 is held -> if_pc=4 and
//     cur_pc=8 stay stable. Release -> next entry is 8.
//  3. redirect_en with redirect_pc=0x1C while stalled -> next cycle
//     if_valid=0, cur_pc=0x1C. Following entry is if_pc=0x1C.
//  4. redirect_pc=0x22 -> cur_pc=0x20, misalign=1 for one cycle only.
//  5. ROM word 0 at 0x48 -> captured with if_pc=0x48, halted=1, cur_pc
//     stays 0x48. Redirect to 0 -> RUN resumes at 0.
//  6. Fetch at PC 0x80 (IMEM_BYTES=128) -> if_fault=1 with that entry.
//     Assert rst mid-stall -> all outputs return to reset values at once.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, feeds the IF/ID register over valid/ready.
// Define FETCH_PERF_CNT_EN to add fetch_count/stall_count performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128
) (
    input  logic        clk,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    input  logic        rst,
    output logic [31:0] cur_pc,
    input  logic [31:0] instruction,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault,
    output logic        misalign,
    output logic        halted
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    logic [1:0]  state_q, state_d;
    logic [31:0] curPc_q, curPc_d;
    logic        valid_q, valid_d;
    logic [31:0] instrPc_q, instrPc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic        misalign_q, misalign_d;
    logic        fire;
    logic        capture;

    assign fire    = (state_q == ST_RUN) && (!valid_q || id_ready);
    // A redirect on a fire cycle discards the word at the old PC.
    assign capture = fire && !redirect_en;

    always_comb begin
        state_d    = state_q;
        curPc_d    = curPc_q;
        valid_d    = valid_q;
        instrPc_d  = instrPc_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        misalign_d = 1'b0;

        if (valid_q && id_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (capture) begin
                    valid_d   = 1'b1;
                    instrPc_d = curPc_q;
                    instr_d   = instruction;
                    fault_d   = (curPc_q >= IMEM_LIMIT);
                    if (instruction == 32'h0) begin
                        state_d = ST_HALT;
                    end else begin
                        curPc_d = curPc_q + 32'd4;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase

        // Redirect overrides everything; BOOT still advances to RUN on its own.
        if (redirect_en) begin
            curPc_d    = {redirect_pc[31:2], 2'b00};
            valid_d    = 1'b0;
            misalign_d = |redirect_pc[1:0];
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            curPc_q    <= RESET_PC;
            valid_q    <= 1'b0;
            instrPc_q  <= 32'h0;
            instr_q    <= 32'h0;
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            curPc_q    <= curPc_d;
            valid_q    <= valid_d;
            instrPc_q  <= instrPc_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCnt_q, stallCnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchCnt_q <= 32'h0;
            stallCnt_q <= 32'h0;
        end else if (!redirect_en) begin
            if (capture) begin
                fetchCnt_q <= fetchCnt_q + 32'd1;
            end
            if ((state_q == ST_RUN) && valid_q && !id_ready) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetchCnt_q;
    assign stall_count = stallCnt_q;
`endif

    assign cur_pc   = curPc_q;
    assign if_valid = valid_q;
    assign if_pc    = instrPc_q;
    assign if_instr = instr_q;
    assign if_fault = fault_q;
    assign misalign = misalign_q;
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed fetch, stall, redirect, halt and fault scenarios.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cur_pc;
    logic [31:0] instruction;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;
    logic        misalign;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int total = 0;
    int bad = 0;
    entry_t expQ[$];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(128)) dut (
        .clk(clk),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count),
        .stall_count(stall_count),
`endif
        .rst(rst),
        .cur_pc(cur_pc),
        .instruction(instruction),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .if_fault(if_fault),
        .misalign(misalign),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // ROM image: a zero padding word at 0x48, a distinct non-zero word elsewhere.
    function automatic logic [31:0] romModel(input logic [31:0] pc);
        if (pc >= 32'd128) return 32'hBAD0_0000 | pc;
        if (pc == 32'h48) return 32'h0;
        return 32'h1000_0013 | {20'b0, pc[6:2], 7'b0};
    endfunction

    assign instruction = romModel(cur_pc);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic redirEn, input logic [31:0] redirPc, input logic ready);
        redirect_en = redirEn;
        redirect_pc = redirPc;
        id_ready    = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        entry_t e;
        e.pc = pc;
        e.instr = instr;
        e.fault = fault;
        expQ.push_back(e);
    endtask

    // Monitor: every accepted IF/ID transfer is compared against the scoreboard head.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && if_valid && id_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedTransfer: got pc %h instr %h expected none", if_pc, if_instr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("xferPc", if_pc, e.pc);
                    checkOutput("xferInstr", if_instr, e.instr);
                    checkOutput("xferFault", {31'b0, if_fault}, {31'b0, e.fault});
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstCurPc", cur_pc, 32'h0);
        checkOutput("rstValid", {31'b0, if_valid}, 32'h0);
        checkOutput("rstHalted", {31'b0, halted}, 32'h0);
        checkOutput("rstMisalign", {31'b0, misalign}, 32'h0);
        rst = 1'b0;

        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("bootNoCapture", {31'b0, if_valid}, 32'h0);
        checkOutput("bootCurPc", cur_pc, 32'h0);

        pushExp(32'h0, 32'h1000_0013, 1'b0);
        pushExp(32'h4, 32'h1000_0093, 1'b0);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("seqIfPc", if_pc, 32'h8);
        checkOutput("seqCurPc", cur_pc, 32'hC);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            checkOutput("stallIfPc", if_pc, 32'h8);
            checkOutput("stallInstr", if_instr, 32'h1000_0113);
            checkOutput("stallCurPc", cur_pc, 32'hC);
        end

        pushExp(32'h8, 32'h1000_0113, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("releaseIfPc", if_pc, 32'hC);

        applyStimulus(1'b1, 32'h1C, 1'b0);
        checkOutput("flushValid", {31'b0, if_valid}, 32'h0);
        checkOutput("redirCurPc", cur_pc, 32'h1C);
        checkOutput("alignedNoMisalign", {31'b0, misalign}, 32'h0);

        pushExp(32'h1C, 32'h1000_0393, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("redirIfPc", if_pc, 32'h1C);

        applyStimulus(1'b1, 32'h22, 1'b1);
        checkOutput("misalignCurPc", cur_pc, 32'h20);
        checkOutput("misalignPulse", {31'b0, misalign}, 32'h1);

        pushExp(32'h20, 32'h1000_0413, 1'b0);
        for (int pc = 32'h24; pc < 32'h48; pc += 4) begin
            pushExp(32'(pc), 32'h1000_0013 | (32'(pc >> 2) << 7), 1'b0);
        end
        pushExp(32'h48, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("misalignCleared", {31'b0, misalign}, 32'h0);

        for (int n = 0; n < 30; n++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            if (halted) break;
        end
        checkOutput("haltReached", {31'b0, halted}, 32'h1);
        checkOutput("haltIfPc", if_pc, 32'h48);
        checkOutput("haltInstr", if_instr, 32'h0);
        checkOutput("haltCurPc", cur_pc, 32'h48);

        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("haltDrained", {31'b0, if_valid}, 32'h0);
        checkOutput("haltHoldPc", cur_pc, 32'h48);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("haltNoCapture", {31'b0, if_valid}, 32'h0);
        checkOutput("haltStays", {31'b0, halted}, 32'h1);

        applyStimulus(1'b1, 32'h0, 1'b1);
        checkOutput("resumeHalted", {31'b0, halted}, 32'h0);
        checkOutput("resumeCurPc", cur_pc, 32'h0);

        pushExp(32'h0, 32'h1000_0013, 1'b0);
        pushExp(32'h4, 32'h1000_0093, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("resumeIfPc", if_pc, 32'h4);

        applyStimulus(1'b1, 32'h7C, 1'b1);
        checkOutput("edgeCurPc", cur_pc, 32'h7C);

        pushExp(32'h7C, 32'h1000_0F93, 1'b0);
        pushExp(32'h80, 32'hBAD0_0080, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("lastInRangeFault", {31'b0, if_fault}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("oobIfPc", if_pc, 32'h80);
        checkOutput("oobFault", {31'b0, if_fault}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("oobNextIfPc", if_pc, 32'h84);
        checkOutput("oobKeepsRunning", cur_pc, 32'h88);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("oobStallIfPc", if_pc, 32'h84);

        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstCurPc", cur_pc, 32'h0);
        checkOutput("asyncRstValid", {31'b0, if_valid}, 32'h0);
        checkOutput("asyncRstIfPc", if_pc, 32'h0);
        checkOutput("asyncRstInstr", if_instr, 32'h0);
        checkOutput("asyncRstFault", {31'b0, if_fault}, 32'h0);
        checkOutput("asyncRstMisalign", {31'b0, misalign}, 32'h0);
        checkOutput("asyncRstHalted", {31'b0, halted}, 32'h0);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
